cacheline_burst_adaptor: RTL and testbench

//  Sits between cache_control/datapath and physical memory, directly downstream of the cache.

---
 rtl/mem_if_pkg.sv | 17 +
 rtl/cacheline_burst_adaptor.sv | 109 ++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the cache-to-memory adaptor.
//   LINE_W / BURST_W / ADDR_W : default widths of the cache line, memory beat and address
//   adaptor_state_t           : burst adaptor FSM states
package mem_if_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cache-line read/write into a BEATS-long burst of BURST_W beats
// on the memory bus, and returns a one-cycle resp_o to the cache when done.
//   clk, rst             : clock, synchronous active-high reset
//   line_i / line_o      : line to write / assembled read line
//   address_i            : line address from the cache
//   read_i / write_i     : cache requests (write wins when both are high)
//   resp_o               : one-cycle completion pulse to the cache
//   burst_i / burst_o    : read beat from memory / write beat to memory
//   address_o            : line-aligned address, held for the whole burst
//   read_o / write_o     : memory requests, high for the whole burst
//   resp_i               : memory beat strobe; low inside a burst stalls it
module cacheline_burst_adaptor
    import mem_if_pkg::*;
#(
    parameter int LINE_W  = mem_if_pkg::LINE_W,
    parameter int BURST_W = mem_if_pkg::BURST_W,
    parameter int ADDR_W  = mem_if_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS_W = $clog2(LINE_W / 8);

    // Clears the byte offset inside a line.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFFS_W) - 64'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

    adaptor_state_t     state, state_nxt;
    logic [BEAT_W-1:0]  beat;
    logic [LINE_W-1:0]  rbuf;
    logic [LINE_W-1:0]  wline;
    logic [ADDR_W-1:0]  addr_q;
    logic               last_beat;

    assign last_beat = resp_i && (beat == LAST_BEAT);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (write_i)     state_nxt = WRITE;
                   else if (read_i) state_nxt = READ;
            READ:  if (last_beat)   state_nxt = DONE;
            WRITE: if (last_beat)   state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Moore outputs; burst_o is only driven during a write burst.
    always_comb begin
        read_o    = (state == READ);
        write_o   = (state == WRITE);
        resp_o    = (state == DONE);
        burst_o   = '0;
        if (state == WRITE)
            burst_o = wline[beat*BURST_W +: BURST_W];
        address_o = addr_q;
        line_o    = rbuf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat   <= '0;
            rbuf   <= '0;
            wline  <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    // Request inputs are only sampled here; later changes are ignored.
                    if (write_i || read_i) begin
                        addr_q <= address_i & ALIGN_MASK;
                        wline  <= line_i;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        rbuf[beat*BURST_W +: BURST_W] <= burst_i;
                        beat <= last_beat ? '0 : beat + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i)
                        beat <= last_beat ? '0 : beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    int n_chk  = 0;
    int n_fail = 0;
    logic [255:0] cur_line;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle, ends in the DONE cycle. stall bit c drops resp_i in cycle c.
    task automatic read_burst(input string tag, input logic [31:0] a, input logic [31:0] exp_a,
                              input logic [3:0][63:0] d, input int stall, input int exp_done,
                              input logic [255:0] exp_line);
        int c = 1;
        int k = 0;
        address_i = a;
        read_i    = 1'b1;
        line_i    = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        step;
        read_i    = 1'b0;
        address_i = 32'hFFFF_FFFF;
        while (k < 4 && c < 20) begin
            check({tag, " read_o"}, 256'(read_o), 256'(1'b1));
            check({tag, " address_o"}, 256'(address_o), 256'(exp_a));
            if (stall[c]) begin
                resp_i  = 1'b0;
                burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                resp_i  = 1'b1;
                burst_i = d[k];
                k++;
            end
            step;
            c++;
        end
        resp_i  = 1'b0;
        burst_i = 64'h0;
        check({tag, " done cycle"}, 256'(c), 256'(exp_done));
        check({tag, " resp_o"}, 256'(resp_o), 256'(1'b1));
        check({tag, " read_o off"}, 256'(read_o), 256'(1'b0));
        check({tag, " line_o"}, line_o, exp_line);
    endtask

    task automatic write_burst(input string tag, input logic [31:0] a, input logic [31:0] exp_a,
                               input logic [255:0] l, input logic both, input logic [255:0] exp_line);
        address_i = a;
        line_i    = l;
        write_i   = 1'b1;
        read_i    = both;
        step;
        write_i   = 1'b0;
        read_i    = 1'b0;
        line_i    = ~l;
        for (int c = 1; c <= 4; c++) begin
            check({tag, " write_o"}, 256'(write_o), 256'(1'b1));
            check({tag, " read_o"}, 256'(read_o), 256'(1'b0));
            check({tag, " address_o"}, 256'(address_o), 256'(exp_a));
            check({tag, " burst_o"}, 256'(burst_o), 256'(l[(c-1)*64 +: 64]));
            resp_i = 1'b1;
            step;
        end
        resp_i = 1'b0;
        check({tag, " resp_o"}, 256'(resp_o), 256'(1'b1));
        check({tag, " write_o off"}, 256'(write_o), 256'(1'b0));
        check({tag, " line_o kept"}, line_o, exp_line);
    endtask

    logic [3:0][63:0] d1, d3, d4, d5;
    logic [255:0]     wl2, wl4, wl6;

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        step; step;
        check("rst read_o",    256'(read_o),    256'(0));
        check("rst write_o",   256'(write_o),   256'(0));
        check("rst resp_o",    256'(resp_o),    256'(0));
        check("rst address_o", 256'(address_o), 256'(0));
        check("rst burst_o",   256'(burst_o),   256'(0));
        check("rst line_o",    line_o,          256'(0));
        rst = 1'b0;

        // spurious resp_i in IDLE
        resp_i = 1'b1; burst_i = 64'hFEED_FACE_FEED_FACE;
        step;
        check("idle resp_i read_o",  256'(read_o),  256'(0));
        check("idle resp_i write_o", 256'(write_o), 256'(0));
        check("idle resp_i resp_o",  256'(resp_o),  256'(0));
        check("idle resp_i line_o",  line_o,        256'(0));
        resp_i = 1'b0; burst_i = '0;
        step;

        // 1: plain read
        d1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        cur_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        read_burst("t1", 32'h0000_1234, 32'h0000_1220, d1, 0, 5, cur_line);
        step;
        check("t1 resp_o pulse", 256'(resp_o), 256'(0));

        // 2: plain write, line_o untouched
        wl2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        write_burst("t2", 32'h4000_005F, 32'h4000_0040, wl2, 1'b0, cur_line);
        step;

        // 3: read with stalls in cycles 2 and 4
        d3 = {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F,
              64'hA5A5_A5A5_5A5A_5A5A, 64'h8000_0000_0000_0001};
        cur_line = {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F,
                    64'hA5A5_A5A5_5A5A_5A5A, 64'h8000_0000_0000_0001};
        read_burst("t3", 32'h0000_8FFF, 32'h0000_8FE0, d3, (1 << 2) | (1 << 4), 7, cur_line);
        step;

        // 4: write then back-to-back read
        wl4 = {64'h4, 64'h3, 64'h2, 64'h1};
        write_burst("t4w", 32'h0000_0020, 32'h0000_0020, wl4, 1'b0, cur_line);
        read_i = 1'b1; address_i = 32'h0000_0100;  // present during DONE: ignored there
        step;
        check("t4 idle read_o", 256'(read_o), 256'(0));
        check("t4 idle resp_o", 256'(resp_o), 256'(0));
        d4 = {64'hF4, 64'hF3, 64'hF2, 64'hF1};
        cur_line = {64'hF4, 64'hF3, 64'hF2, 64'hF1};
        read_burst("t4r", 32'h0000_0100, 32'h0000_0100, d4, 0, 5, cur_line);
        step;

        // 5: reset after two beats of a read
        address_i = 32'h0000_2040; read_i = 1'b1;
        step;
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = 64'h5151; step;
        resp_i = 1'b1; burst_i = 64'h5252; step;
        rst = 1'b1; burst_i = 64'h5353;
        step;
        rst = 1'b0; resp_i = 1'b0; burst_i = '0;
        check("t5 read_o",    256'(read_o),    256'(0));
        check("t5 write_o",   256'(write_o),   256'(0));
        check("t5 resp_o",    256'(resp_o),    256'(0));
        check("t5 address_o", 256'(address_o), 256'(0));
        check("t5 burst_o",   256'(burst_o),   256'(0));
        check("t5 line_o",    line_o,          256'(0));
        d5 = {64'h9999, 64'h8888, 64'h7777, 64'h6666};
        cur_line = {64'h9999, 64'h8888, 64'h7777, 64'h6666};
        read_burst("t5r", 32'h0000_2040, 32'h0000_2040, d5, 0, 5, cur_line);
        step;

        // 6: read_i and write_i together -> write
        wl6 = {64'h6666_0003, 64'h6666_0002, 64'h6666_0001, 64'h6666_0000};
        write_burst("t6", 32'hABCD_EF01, 32'hABCD_EF00, wl6, 1'b1, cur_line);
        step;
        check("t6 idle resp_o", 256'(resp_o), 256'(0));
        check("t6 idle read_o", 256'(read_o), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
